// File: rtl/window_collector.sv
// 3x3 window collector with odd-even transposition median sort and ready/valid output.
// Define WINDOW_COLLECTOR_MINMAX_EN to also expose the window minimum and maximum.
module window_collector #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            countX,
  input  logic [1:0]            countY,
  input  logic                  windowValid,
  input  logic [DATA_WIDTH-1:0] pixelIn,
  input  logic                  pixelValid,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] medianOut,
  output logic                  medianValid,
  input  logic                  medianReady,
  output logic [2:0]            errFlags
`ifdef WINDOW_COLLECTOR_MINMAX_EN
  ,
  output logic [DATA_WIDTH-1:0] minOut,
  output logic [DATA_WIDTH-1:0] maxOut
`endif
);

  typedef enum logic [1:0] {COLLECT, SORT, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [8:0]            fill_q, fill_d, fill_now;
  logic [DATA_WIDTH-1:0] slot_q [9];
  logic [DATA_WIDTH-1:0] slot_d [9];
  logic [3:0]            pass_q, pass_d;
  logic [DATA_WIDTH-1:0] median_q, median_d;
  logic                  mvalid_q, mvalid_d;
  logic [2:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] min_q, min_d, max_q, max_d;

  logic [DATA_WIDTH-1:0] even_res [9];
  logic [DATA_WIDTH-1:0] odd_res  [9];
  logic [DATA_WIDTH-1:0] pass_res [9];

  logic       in_range;
  logic       wr_en;
  logic [3:0] wr_idx;

  assign in_range = (countX != 2'd3) && (countY != 2'd3);
  assign wr_en    = pixelValid && in_range && (state_q == COLLECT);
  assign wr_idx   = {1'b0, countY, 1'b0} + {2'b00, countY} + {2'b00, countX};

  // Both pass flavours are built in parallel; pass parity selects which one lands.
  assign even_res[8] = slot_q[8];
  assign odd_res[0]  = slot_q[0];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cmp_swap
      assign even_res[2*gi]   = (slot_q[2*gi] > slot_q[2*gi+1]) ? slot_q[2*gi+1] : slot_q[2*gi];
      assign even_res[2*gi+1] = (slot_q[2*gi] > slot_q[2*gi+1]) ? slot_q[2*gi]   : slot_q[2*gi+1];
      assign odd_res[2*gi+1]  = (slot_q[2*gi+1] > slot_q[2*gi+2]) ? slot_q[2*gi+2] : slot_q[2*gi+1];
      assign odd_res[2*gi+2]  = (slot_q[2*gi+1] > slot_q[2*gi+2]) ? slot_q[2*gi+1] : slot_q[2*gi+2];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      pass_res[i] = pass_q[0] ? odd_res[i] : even_res[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    fill_now = fill_q;
    slot_d   = slot_q;
    pass_d   = pass_q;
    median_d = median_q;
    mvalid_d = mvalid_q;
    err_d    = err_q;
    min_d    = min_q;
    max_d    = max_q;

    if (pixelValid && !in_range) begin
      err_d[0] = 1'b1;
    end

    case (state_q)
      COLLECT: begin
        for (int i = 0; i < 9; i++) begin
          if (wr_en && (wr_idx == 4'(i))) begin
            slot_d[i]   = pixelIn;
            fill_now[i] = 1'b1;
          end
        end
        fill_d = fill_now;
        // Completeness includes a pixel written in the same cycle as windowValid.
        if (windowValid) begin
          if (&fill_now) begin
            state_d = SORT;
            pass_d  = 4'd0;
          end else begin
            err_d[1] = 1'b1;
            fill_d   = '0;
          end
        end
      end
      SORT: begin
        if (pixelValid || windowValid) begin
          err_d[2] = 1'b1;
        end
        slot_d = pass_res;
        pass_d = pass_q + 4'd1;
        if (pass_q == 4'd8) begin
          state_d  = OUTPUT;
          median_d = pass_res[4];
          min_d    = pass_res[0];
          max_d    = pass_res[8];
          mvalid_d = 1'b1;
        end
      end
      OUTPUT: begin
        if (pixelValid || windowValid) begin
          err_d[2] = 1'b1;
        end
        if (medianReady) begin
          state_d  = COLLECT;
          mvalid_d = 1'b0;
          fill_d   = '0;
          pass_d   = 4'd0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= COLLECT;
      fill_q   <= '0;
      pass_q   <= '0;
      median_q <= '0;
      mvalid_q <= 1'b0;
      err_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      for (int i = 0; i < 9; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      pass_q   <= pass_d;
      median_q <= median_d;
      mvalid_q <= mvalid_d;
      err_q    <= err_d;
      min_q    <= min_d;
      max_q    <= max_d;
      for (int i = 0; i < 9; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign busy        = (state_q != COLLECT);
  assign medianOut   = median_q;
  assign medianValid = mvalid_q;
  assign errFlags    = err_q;

`ifdef WINDOW_COLLECTOR_MINMAX_EN
  assign minOut = min_q;
  assign maxOut = max_q;
`else
  logic unused_minmax;
  assign unused_minmax = ^{min_q, max_q};
`endif

endmodule

// File: doc/window_collector.md
WINDOW_COLLECTOR -- requirements
Module: window_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port countX  input  2  window column index from the window counter; valid values 0..2.
REQ-005 SHALL have port countY  input  2  window row index from the window counter; valid values 0..2.
REQ-006 SHALL have port windowValid  input  1  counter pulse: current 3x3 window fully enumerated.
REQ-007 SHALL have port pixelIn  input  DATA_WIDTH  pixel for position (countX,countY).
REQ-008 SHALL have port pixelValid  input  1  pixelIn qualifier.
REQ-009 SHALL have port busy  output  1  high while not in COLLECT.
REQ-010 SHALL have port medianOut  output  DATA_WIDTH  median of the 9 window pixels.
REQ-011 SHALL have port medianValid  output  1  medianOut qualifier.
REQ-012 SHALL have port medianReady  input  1  downstream accept.
REQ-013 SHALL have port errFlags  output  3  sticky flags: [0] index out of range, [1] incomplete window, [2] overrun.

Function
REQ-014 SHALL implement FSM states COLLECT, SORT, OUTPUT; reset state COLLECT.
REQ-015 In COLLECT, on pixelValid with countX<=2 and countY<=2: write pixelIn to slot 3*countY+countX and set its fill bit; a rewrite overwrites.
REQ-016 On pixelValid with countX==3 or countY==3: discard the pixel and set errFlags[0].
REQ-017 In COLLECT, on windowValid: evaluate completeness including any write in the same cycle; if all 9 fill bits are set, go to SORT next cycle.
REQ-018 On windowValid with fewer than 9 fill bits set: set errFlags[1], clear all fill bits, and stay in COLLECT.
REQ-019 SORT SHALL run an ascending odd-even transposition sort on slots 0..8, one pass per cycle, for exactly 9 passes.
- Even passes: compare-swap pairs (0,1)(2,3)(4,5)(6,7).
- Odd passes: compare-swap pairs (1,2)(3,4)(5,6)(7,8).
- Pass counter is 4 bits wide.
REQ-020 After pass 9, go to OUTPUT: medianOut = slot 4, medianValid = 1.
REQ-021 medianValid and medianOut SHALL hold stable until a cycle with medianReady=1.
REQ-022 On that medianReady cycle, the next cycle SHALL return to COLLECT with all fill bits cleared and medianValid = 0.
REQ-023 Latency: windowValid accepted in cycle N -> medianValid first high in cycle N+10.
REQ-024 pixelValid or windowValid in SORT/OUTPUT SHALL be ignored and set errFlags[2]; slot contents SHALL be unaffected.
REQ-025 Comparisons SHALL be unsigned, DATA_WIDTH bits, with no widening; equal values are not swapped.
REQ-026 errFlags bits SHALL be sticky, cleared only by reset.

Reset
REQ-027 On reset=1 at a clock edge: state COLLECT, fill bits 0, slots 0, pass counter 0, medianOut 0, medianValid 0, busy 0, errFlags 0.
REQ-028 Reset asserted mid-SORT or mid-OUTPUT SHALL abort the operation immediately; no medianValid follows.

Configuration
REQ-029 Macro WINDOW_COLLECTOR_MINMAX_EN, when defined, SHALL add outputs minOut and maxOut (DATA_WIDTH each) = slot 0 and slot 8 after the sort, qualified by medianValid and reset to 0.
REQ-030 Without WINDOW_COLLECTOR_MINMAX_EN, minOut and maxOut ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Pixels 9,8,7,6,5,4,3,2,1 written raster order (0,0)..(2,2), windowValid with last pixel, medianReady=1 -> medianOut=5 at N+10; minOut=1, maxOut=9 if macro defined.
REQ-032 Pixels all 200 except (1,1)=0 -> medianOut=200; medianValid held for 5 cycles with medianReady=0, then drops 1 cycle after medianReady=1.
REQ-033 Only 8 pixels written, then windowValid -> errFlags=3'b010, no medianValid, busy stays 0; the next full window yields a correct median.
REQ-034 pixelValid with countX=3 -> errFlags[0]=1, slots unchanged; pixelValid during SORT -> errFlags[2]=1, median unaffected.
REQ-035 reset pulsed at the 4th SORT cycle -> all outputs 0 next cycle, no medianValid, fresh window then processes normally.
